// File: rtl/hex2ascii_stream.sv
// Streams an N-nibble hex word out as 7-bit ASCII characters, most significant nibble first.
// Optional "0x" prefix per word when HEX2ASCII_PREFIX_EN is defined.
module hex2ascii_stream #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    input  logic                   in_lower,
    input  logic                   in_zsup,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_char,
    output logic                   out_last
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

`ifdef HEX2ASCII_PREFIX_EN
    typedef enum logic [1:0] {S_IDLE, S_PRE0, S_PRE1, S_DIGIT} state_t;
    localparam state_t FIRST_STATE = S_PRE0;
`else
    typedef enum logic [1:0] {S_IDLE, S_DIGIT} state_t;
    localparam state_t FIRST_STATE = S_DIGIT;
`endif

    state_t                 state, state_n;
    logic [CW-1:0]          idx, idx_n;
    logic [4*NIBBLES-1:0]   data_r;
    logic                   lower_r;
    logic                   load;
    logic                   accept;
    logic                   out_hs;
    logic [3:0]             nib;

    function automatic logic [6:0] encode(input logic [3:0] d, input logic lower);
        logic [6:0] base;
        if (d <= 4'd9)
            base = 7'h30;
        else if (lower)
            base = 7'h57;
        else
            base = 7'h37;
        return base + {3'b000, d};
    endfunction

    // Highest nonzero nibble wins; an all-zero word still emits its nibble 0.
    function automatic logic [CW-1:0] start_idx(input logic [4*NIBBLES-1:0] d,
                                                input logic zsup);
        logic [CW-1:0] r;
        r = '0;
        if (!zsup) begin
            r = CW'(NIBBLES - 1);
        end else begin
            for (int i = 0; i < NIBBLES; i++)
                if (d[4*i +: 4] != 4'h0)
                    r = CW'(i);
        end
        return r;
    endfunction

    assign out_valid = (state != S_IDLE);
    assign out_last  = (state == S_DIGIT) && (idx == '0);
    assign out_hs    = out_valid && out_ready;
    // Ready on the last handshake too, so consecutive words run without a bubble.
    assign in_ready  = (state == S_IDLE) || (out_hs && out_last);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_r  <= in_data;
            lower_r <= in_lower;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept)
                    load = 1'b1;
            end
`ifdef HEX2ASCII_PREFIX_EN
            S_PRE0: begin
                if (out_hs)
                    state_n = S_PRE1;
            end
            S_PRE1: begin
                if (out_hs)
                    state_n = S_DIGIT;
            end
`endif
            S_DIGIT: begin
                if (out_hs) begin
                    if (idx != '0)
                        idx_n = idx - 1'b1;
                    else if (accept)
                        load = 1'b1;
                    else
                        state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (load) begin
            state_n = FIRST_STATE;
            idx_n   = start_idx(in_data, in_zsup);
        end
    end

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++)
            if (idx == CW'(i))
                nib = data_r[4*i +: 4];
    end

    // Driven purely from registered state, so the character holds while stalled.
    always_comb begin
        out_char = 7'h00;
        case (state)
`ifdef HEX2ASCII_PREFIX_EN
            S_PRE0:  out_char = 7'h30;
            S_PRE1:  out_char = 7'h78;
`endif
            S_DIGIT: out_char = encode(nib, lower_r);
            default: out_char = 7'h00;
        endcase
    end

endmodule

// File: tb/tb_hex2ascii_stream.sv
// Scoreboard bench for hex2ascii_stream (NIBBLES=4); follows HEX2ASCII_PREFIX_EN if defined.
module tb_hex2ascii_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_lower;
    logic        in_zsup;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_char;
    logic        out_last;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t34 = -1;
    int t35 = -1;
    int stall41 = 0;

    logic [7:0] sb[$];  // {last, char}

    hex2ascii_stream #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lower(in_lower), .in_zsup(in_zsup),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops on each output handshake, checks held value while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_char", {24'h0, out_last, out_char}, 32'hFFFF_FFFF);
            end else if (out_ready) begin
                check("char", {24'h0, out_last, out_char}, {24'h0, sb[0]});
                if (out_last)
                    check("in_ready_on_last", {31'h0, in_ready}, 32'h1);
                if (out_char == 7'h34) t34 = cyc;
                if (out_char == 7'h35) t35 = cyc;
                void'(sb.pop_front());
            end else begin
                check("held_char", {24'h0, out_last, out_char}, {24'h0, sb[0]});
                if (out_char == 7'h41) stall41++;
            end
        end
    end

    // exp holds up to four characters, first in bits [27:21].
    task automatic send(input logic [15:0] d, input logic lower, input logic zsup,
                        input logic [27:0] exp, input int n);
        int cnt;
`ifdef HEX2ASCII_PREFIX_EN
        sb.push_back({1'b0, 7'h30});
        sb.push_back({1'b0, 7'h78});
`endif
        for (int k = 0; k < n; k++)
            sb.push_back({(k == n - 1), exp[27 - 7*k -: 7]});
        in_data  = d;
        in_lower = lower;
        in_zsup  = zsup;
        in_valid = 1'b1;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            if (cnt > 200) begin
                check("accept_timeout", 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int cnt;
        cnt = 0;
        while ((sb.size() != 0 || out_valid) && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({name, "_drained"}, {31'h0, (sb.size() == 0)}, 32'h1);
        check({name, "_idle_valid"}, {31'h0, out_valid}, 32'h0);
        check({name, "_idle_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_lower = 1'b0;
        in_zsup = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_char", {25'h0, out_char}, 32'h0);
        check("rst_out_last", {31'h0, out_last}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(16'h1A3F, 1'b0, 1'b0, {7'h31, 7'h41, 7'h33, 7'h46}, 4);
        drain("t1");

        send(16'hBEEF, 1'b1, 1'b0, {7'h62, 7'h65, 7'h65, 7'h66}, 4);
        drain("t2a");
        send(16'hBEEF, 1'b0, 1'b0, {7'h42, 7'h45, 7'h45, 7'h46}, 4);
        drain("t2b");

        send(16'h00C0, 1'b0, 1'b1, {7'h43, 7'h30, 14'h0}, 2);
        drain("t3a");
        send(16'h0000, 1'b0, 1'b1, {7'h30, 21'h0}, 1);
        drain("t3b");

        // Stall three cycles on the second digit.
        send(16'h1A3F, 1'b0, 1'b0, {7'h31, 7'h41, 7'h33, 7'h46}, 4);
`ifdef HEX2ASCII_PREFIX_EN
        repeat (2) @(posedge clk);
        #1;
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("t4");
        check("t4_stall_cycles", stall41, 3);

        send(16'h1234, 1'b0, 1'b0, {7'h31, 7'h32, 7'h33, 7'h34}, 4);
        send(16'h5678, 1'b0, 1'b0, {7'h35, 7'h36, 7'h37, 7'h38}, 4);
        drain("t5");
`ifdef HEX2ASCII_PREFIX_EN
        check("t5_gap", t35 - t34, 3);
`else
        check("t5_gap", t35 - t34, 1);
`endif

        // Abandon a word after two characters.
        send(16'h1A3F, 1'b0, 1'b0, {7'h31, 7'h41, 7'h33, 7'h46}, 4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        check("t6_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("t6_rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("t6_rst_out_last", {31'h0, out_last}, 32'h0);
        check("t6_rst_out_char", {25'h0, out_char}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(16'h00FF, 1'b0, 1'b0, {7'h30, 7'h30, 7'h46, 7'h46}, 4);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hex2ascii_stream.md
Name: hex2ascii_stream

Overview:
Parametrised sequential successor to the combinational hex-to-ASCII converters. Accepts an N-nibble hex word over a valid/ready handshake and emits one 7-bit ASCII character per output handshake, most significant nibble first. Supports a runtime lowercase mode and leading-zero suppression. Sits between a data source and a character sink such as a UART transmitter or a text buffer.

Parameters:
NIBBLES, 4, hex digits per input word; legal range 1..16.
CW, $clog2(NIBBLES) (min 1), width of the nibble index counter; derived, not overridden.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  4*NIBBLES  hex word, nibble NIBBLES-1 is the most significant
in_lower  input  1  1: a-f lowercase; 0: A-F uppercase; sampled on input handshake
in_zsup  input  1  1: suppress leading zeros; sampled on input handshake
out_valid  output  1  out_char valid
out_ready  input  1  sink accepts the character
out_char  output  7  ASCII character
out_last  output  1  marks the final character of the current word

Behaviour:
- Reset: clk is the only clock. rst is asynchronous and active-high. While rst is high, out_valid=0, out_char=7'h00, out_last=0, FSM=IDLE, and in_ready=1.
- Input handshake: in_valid && in_ready at a rising edge. in_data, in_lower and in_zsup are captured into internal registers.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This term is combinational from out_ready and allows back-to-back words with no bubble.
- Latency: the first character is valid in the cycle after the input handshake, and out_valid rises on that edge.
- Output handshake: out_valid && out_ready at an edge advances to the next character.
  - While out_valid=1 and out_ready=0, out_char and out_last hold stable.
  - Once out_valid is asserted, it does not drop until the handshake completes.
- Character encoding (nibble d):
  - d<=9: 7'h30+d.
  - d>=10, in_lower=0: 7'h37+d ('A'..'F').
  - d>=10, in_lower=1: 7'h57+d ('a'..'f').
  - All arithmetic is 7-bit. No overflow is possible.
- FSM states:
  - IDLE: out_valid=0. Input handshake -> PREFIX (if enabled) or DIGIT.
  - PREFIX: emits "0x" (see Optional Feature) -> DIGIT.
  - DIGIT: emits nibble[idx]. On output handshake:
    - idx>0: idx decrements.
    - idx==0 and a new input handshake occurs in the same cycle: reload and go to PREFIX/DIGIT.
    - idx==0 otherwise: go to IDLE.
- Start index at input handshake:
  - in_zsup=0: idx=NIBBLES-1.
  - in_zsup=1: idx = position of the most significant nonzero nibble.
  - in_zsup=1 and the word is all zero: idx=0, so exactly one '0' (7'h30) is emitted.
- out_last=1 only while the idx==0 digit is presented.
- Simultaneous input and output handshake on the last character: the new word's first character appears on the next cycle. No drop, no duplicate.
- in_valid while not ready is ignored. The source must hold its data; the block does not latch it.
- Reset mid-word: the current word is abandoned and outputs clear immediately (asynchronously). After rst falls, the block accepts a fresh word from IDLE.

Optional Feature:
Macro HEX2ASCII_PREFIX_EN.
- Defined: each word is preceded by 7'h30 ('0') then 7'h78 ('x'), with out_last=0 on both.
  - 'x' is always lowercase, regardless of in_lower.
  - The prefix is emitted even when in_zsup suppresses digits.
  - Each prefix character needs its own output handshake.
- Undefined: the PREFIX state is not compiled, and the first character is the first digit.

Test Plan:
1. NIBBLES=4, in_data=16'h1A3F, in_lower=0, in_zsup=0, out_ready=1 -> out_char 7'h31,7'h41,7'h33,7'h46 on four consecutive cycles; out_last only on 7'h46; then IDLE.
2. in_data=16'hBEEF, in_lower=1 -> 7'h62,7'h65,7'h65,7'h66; same word with in_lower=0 -> 7'h42,7'h45,7'h45,7'h46.
3. in_zsup=1: 16'h00C0 -> 7'h43,7'h30, with out_last on 7'h30. 16'h0000 -> a single 7'h30 with out_last=1.
4. 16'h1A3F with out_ready low for 3 cycles while 7'h41 is presented -> 7'h41 held stable for 4 cycles; the sequence is complete with no skip or duplicate.
5. Two words 16'h1234 then 16'h5678 with in_valid held and out_ready=1:
   - in_ready pulses in the same cycle as the 7'h34 handshake;
   - 7'h35 follows 7'h34 on the next cycle, with no bubble.
6. rst pulsed after 2 characters of 16'h1A3F -> out_valid=0 and in_ready=1 during reset. The next word 16'h00FF then emits 7'h30,7'h30,7'h46,7'h46 cleanly.
   - With HEX2ASCII_PREFIX_EN defined, the same word emits 7'h30,7'h78 first.
